// File: rtl/oam_dma_if.sv
// oam_dma bus bundle: CPU memory read port (registered read) and
// the byte-wide PPU OAM write port.
interface oam_dma_if #(
    parameter int ADDR_W = 16
) ();

    logic [ADDR_W-1:0] raddr;
    logic [7:0]        rdata;
    logic              oam_wen;
    logic [7:0]        oam_addr;
    logic [7:0]        oam_wdata;

    modport master (
        output raddr,
        input  rdata,
        output oam_wen,
        output oam_addr,
        output oam_wdata
    );

    modport slave (
        input  raddr,
        output rdata,
        input  oam_wen,
        input  oam_addr,
        input  oam_wdata
    );

endinterface

// File: rtl/oam_dma.sv
// oam_dma: $4014 sprite DMA, copies LEN bytes of one CPU page into OAM.
// Optional DMA_ALIGN_EN inserts an ALIGN cycle when the CPU was on an odd cycle.
module oam_dma #(
    parameter int LEN    = 256,
    parameter int ADDR_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig_i,
    input  logic [7:0] page_i,
    input  logic [7:0] oam_start_i,
    input  logic       cpu_odd_i,
    oam_dma_if.master  bus,
    output logic       cpu_stall_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [7:0] LAST = 8'(LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
`ifdef DMA_ALIGN_EN
        S_ALIGN,
`endif
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        idx_q, idx_d;
    logic [7:0]        page_q, page_d;
    logic [7:0]        start_q, start_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              wen_q, wen_d;
    logic [7:0]        oaddr_q, oaddr_d;
    logic              stall_q, stall_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] src_cur;
    logic [ADDR_W-1:0] src_nxt;

`ifdef DMA_ALIGN_EN
    logic odd_q, odd_d;
`else
    logic unused_cpu_odd;
    assign unused_cpu_odd = cpu_odd_i;
`endif

    assign src_cur = ADDR_W'({page_q, idx_q});
    assign src_nxt = ADDR_W'({page_q, idx_q + 8'd1});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            page_q  <= '0;
            start_q <= '0;
            raddr_q <= '0;
            wen_q   <= 1'b0;
            oaddr_q <= '0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            start_q <= start_d;
            raddr_q <= raddr_d;
            wen_q   <= wen_d;
            oaddr_q <= oaddr_d;
            stall_q <= stall_d;
            done_q  <= done_d;
        end
    end

`ifdef DMA_ALIGN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) odd_q <= 1'b0;
        else        odd_q <= odd_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        start_d = start_q;
        raddr_d = raddr_q;
        wen_d   = 1'b0;
        oaddr_d = oaddr_q;
        stall_d = stall_q;
        done_d  = 1'b0;
`ifdef DMA_ALIGN_EN
        odd_d   = odd_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (trig_i) begin
                    page_d  = page_i;
                    start_d = oam_start_i;
                    idx_d   = '0;
                    stall_d = 1'b1;
                    state_d = S_HALT;
`ifdef DMA_ALIGN_EN
                    odd_d   = cpu_odd_i;
`endif
                end
            end
            S_HALT: begin
`ifdef DMA_ALIGN_EN
                if (odd_q) begin
                    state_d = S_ALIGN;
                end else begin
                    state_d = S_READ;
                    raddr_d = src_cur;
                end
`else
                state_d = S_READ;
                raddr_d = src_cur;
`endif
            end
`ifdef DMA_ALIGN_EN
            S_ALIGN: begin
                state_d = S_READ;
                raddr_d = src_cur;
            end
`endif
            S_READ: begin
                // the byte read now is written next cycle, at start+idx
                wen_d   = 1'b1;
                oaddr_d = start_q + idx_q;
                if (idx_q == LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    raddr_d = src_nxt;
                end
            end
            S_DRAIN: begin
                stall_d = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.raddr     = raddr_q;
    assign bus.oam_wen   = wen_q;
    assign bus.oam_addr  = oaddr_q;
    assign bus.oam_wdata = bus.rdata;

    assign cpu_stall_o = stall_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: scoreboard bench for oam_dma, one LEN=256 and one LEN=1
// instance sharing a registered-read memory model.
module tb_oam_dma;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

`ifdef DMA_ALIGN_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    logic       trig, odd, stall, busy, done;
    logic [7:0] page, start;
    logic       trig1, stall1, busy1, done1;
    logic [7:0] page1, start1;

    oam_dma_if #(.ADDR_W(16)) bus  ();
    oam_dma_if #(.ADDR_W(16)) bus1 ();

    oam_dma #(.LEN(256), .ADDR_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig_i     (trig),
        .page_i     (page),
        .oam_start_i(start),
        .cpu_odd_i  (odd),
        .bus        (bus),
        .cpu_stall_o(stall),
        .busy_o     (busy),
        .done_o     (done)
    );

    oam_dma #(.LEN(1), .ADDR_W(16)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig_i     (trig1),
        .page_i     (page1),
        .oam_start_i(start1),
        .cpu_odd_i  (1'b0),
        .bus        (bus1),
        .cpu_stall_o(stall1),
        .busy_o     (busy1),
        .done_o     (done1)
    );

    logic [7:0] mem [0:65535];

    logic [15:0] wq[$];
    int          tdone[$];
    int          tstall[$];
    int          scnt;
    logic [15:0] wq1[$];
    int          tdone1[$];
    int          tstall1[$];
    int          scnt1;

    function automatic logic [7:0] memf(input logic [7:0] pg,
                                        input logic [7:0] i);
        if (pg == 8'h02) return i ^ 8'h5A;
        return i + pg * 8'd37;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        bus.rdata  <= mem[bus.raddr];
        bus1.rdata <= mem[bus1.raddr];
    end

    // monitor: pops expected writes / done timing whenever the DUT presents them
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.oam_wen) begin
                if (wq.size() == 0)
                    chk("write_unexpected", {bus.oam_addr, bus.oam_wdata}, 32'hFFFF_FFFF);
                else
                    chk("write", {bus.oam_addr, bus.oam_wdata}, wq.pop_front());
            end
            if (stall) scnt++;
            if (done) begin
                if (tdone.size() == 0) begin
                    chk("done_unexpected", cyc, 32'hFFFF_FFFF);
                end else begin
                    chk("done_cycle", cyc, tdone.pop_front());
                    chk("stall_len", scnt, tstall.pop_front());
                end
                scnt = 0;
            end
            if (bus1.oam_wen) begin
                if (wq1.size() == 0)
                    chk("w1_unexpected", {bus1.oam_addr, bus1.oam_wdata}, 32'hFFFF_FFFF);
                else
                    chk("w1", {bus1.oam_addr, bus1.oam_wdata}, wq1.pop_front());
            end
            if (stall1) scnt1++;
            if (done1) begin
                if (tdone1.size() == 0) begin
                    chk("done1_unexpected", cyc, 32'hFFFF_FFFF);
                end else begin
                    chk("done1_cycle", cyc, tdone1.pop_front());
                    chk("stall1_len", scnt1, tstall1.pop_front());
                end
                scnt1 = 0;
            end
        end
    end

    task automatic do_trig(input logic [7:0] pg, input logic [7:0] st,
                           input logic od, input bit push, output int t);
        int ex;
        @(negedge clk);
        trig  = 1'b1;
        page  = pg;
        start = st;
        odd   = od;
        t     = cyc + 1;
        ex    = (ALN && od) ? 1 : 0;
        if (push) begin
            for (int i = 0; i < 256; i++)
                wq.push_back({st + 8'(i), memf(pg, 8'(i))});
            tdone.push_back(t + 258 + ex);
            tstall.push_back(258 + ex);
        end
        @(negedge clk);
        trig = 1'b0;
        odd  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((tdone.size() != 0 || tdone1.size() != 0) && n < 700) begin
            @(negedge clk);
            n++;
        end
        chk("timeout", tdone.size() + tdone1.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t;
        cyc    = 0;
        checks = 0;
        errors = 0;
        scnt   = 0;
        scnt1  = 0;
        rst_n  = 1'b0;
        trig   = 1'b0;
        page   = '0;
        start  = '0;
        odd    = 1'b0;
        trig1  = 1'b0;
        page1  = '0;
        start1 = '0;
        for (int a = 0; a < 65536; a++)
            mem[a] = memf(8'(a >> 8), 8'(a));

        repeat (3) @(negedge clk);
        chk("rst_raddr", bus.raddr, 0);
        chk("rst_wen", bus.oam_wen, 0);
        chk("rst_oaddr", bus.oam_addr, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic copy
        do_trig(8'h02, 8'h00, 1'b0, 1'b1, t);
        wait_idle();
        chk("raddr_hold", bus.raddr, 16'h02FF);

        // wrap, odd parity (adds ALIGN only in the align build)
        do_trig(8'h03, 8'hF0, 1'b1, 1'b1, t);
        wait_idle();

        // retrigger while busy and in the done cycle
        do_trig(8'h02, 8'h10, 1'b0, 1'b1, t);
        while (cyc < t + 49) @(negedge clk);
        trig  = 1'b1; page = 8'h07; start = 8'h80;
        @(negedge clk);
        trig  = 1'b0;
        while (cyc < t + 258) @(negedge clk);
        trig  = 1'b1; page = 8'h07; start = 8'h80;
        @(negedge clk);
        trig  = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        chk("busy_after_retrig", busy, 0);
        chk("raddr_retrig", bus.raddr, 16'h02FF);

        // asynchronous reset mid-transfer
        do_trig(8'h04, 8'h40, 1'b0, 1'b1, t);
        while (cyc < t + 98) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stall", stall, 0);
        chk("arst_wen", bus.oam_wen, 0);
        chk("arst_busy", busy, 0);
        wq.delete();
        tdone.delete();
        tstall.delete();
        scnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_trig(8'h02, 8'h20, 1'b0, 1'b1, t);
        wait_idle();

        // LEN=1 instance
        @(negedge clk);
        trig1  = 1'b1;
        page1  = 8'h10;
        start1 = 8'h33;
        t      = cyc + 1;
        wq1.push_back({8'h33, memf(8'h10, 8'h00)});
        tdone1.push_back(t + 3);
        tstall1.push_back(3);
        @(negedge clk);
        trig1 = 1'b0;
        wait_idle();
        chk("len1_raddr", bus1.raddr, 16'h1000);
        chk("len1_busy", busy1, 0);
        chk("wq_empty", wq.size() + wq1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
